issue_div_fifo: RTL and testbench

Per-divider issue queue between the issue stage and `execute_div`. The issue stage pushes dispatched divide micro-ops (`issue_execute_pack_t`). `execute_div` reads the head through a show-ahead output and pops it when it accepts an op. There is one instance per divider, `DIV_UNIT_NUM` in total. A commit-stage flush empties the queue.

---
 rtl/issue_div_fifo_pkg.sv | 45 ++++
 rtl/issue_div_fifo.sv | 87 ++++++++
 tb/tb_issue_div_fifo.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/issue_div_fifo_pkg.sv
// Shared issue/commit pack types and sizing constants used by the divider issue queue.
package issue_div_fifo_pkg;

    localparam int ISSUE_DIV_FIFO_SIZE = 4;
    localparam int DIV_UNIT_NUM        = 1;
    localparam int ROB_ID_WIDTH        = 7;
    localparam int PHY_REG_ID_WIDTH    = 6;

    typedef enum logic [4:0] {
        DIV_OP_DIV  = 5'd0,
        DIV_OP_DIVU = 5'd1,
        DIV_OP_REM  = 5'd2,
        DIV_OP_REMU = 5'd3
    } div_op_t;

    typedef union packed {
        div_op_t    div;
        logic [4:0] raw_data;
    } sub_op_t;

    typedef struct packed {
        logic                        enable;
        logic                        valid;
        logic [31:0]                 pc;
        logic [31:0]                 value;
        logic                        has_exception;
        logic [3:0]                  exception_id;
        logic [31:0]                 exception_value;
        logic [ROB_ID_WIDTH-1:0]     rob_id;
        logic                        rd_enable;
        logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
        logic [31:0]                 src1_value;
        logic [31:0]                 src2_value;
        sub_op_t                     sub_op;
    } issue_execute_pack_t;

    typedef struct packed {
        logic                    enable;
        logic                    flush;
        logic [ROB_ID_WIDTH-1:0] next_handle_rob_id;
        logic                    has_exception;
        logic [31:0]             exception_pc;
    } commit_feedback_pack_t;

endpackage

// File: rtl/issue_div_fifo.sv
// Per-divider issue queue: show-ahead head, 1-cycle push/pop latency, no bypass when empty.
// Push while full is dropped (producer must watch full); commit flush empties the queue at the edge.
module issue_div_fifo
    import issue_div_fifo_pkg::*;
#(
    parameter int DEPTH = ISSUE_DIV_FIFO_SIZE,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  issue_execute_pack_t   issue_div_fifo_data_in,
    input  logic                  issue_div_fifo_push,
    output logic                  issue_div_fifo_full,
    output logic                  issue_div_fifo_empty,
    output logic [CNT_W-1:0]      issue_div_fifo_count,
    output issue_execute_pack_t   issue_div_fifo_data_out,
    output logic                  issue_div_fifo_data_out_valid,
    input  logic                  issue_div_fifo_pop,
    input  commit_feedback_pack_t commit_feedback_pack
);

    localparam int PTR_W = $clog2(DEPTH);

    issue_execute_pack_t mem_q [DEPTH];
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic flush;
    logic push_acc;
    logic pop_acc;
    logic cf_unused;

    assign cf_unused = ^{commit_feedback_pack.next_handle_rob_id,
                         commit_feedback_pack.has_exception,
                         commit_feedback_pack.exception_pc};

    assign flush    = commit_feedback_pack.enable && commit_feedback_pack.flush;
    assign issue_div_fifo_full  = (count_q == CNT_W'(DEPTH));
    assign issue_div_fifo_empty = (count_q == '0);
    // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
    assign push_acc = issue_div_fifo_push && !issue_div_fifo_full;
    assign pop_acc  = issue_div_fifo_pop && !issue_div_fifo_empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_acc) wptr_d = wptr_q + PTR_W'(1);
            if (pop_acc)  rptr_d = rptr_q + PTR_W'(1);
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push_acc) begin
            mem_q[wptr_q] <= issue_div_fifo_data_in;
        end
    end

    assign issue_div_fifo_count          = count_q;
    assign issue_div_fifo_data_out_valid = !issue_div_fifo_empty;
    assign issue_div_fifo_data_out       = issue_div_fifo_empty ? '0 : mem_q[rptr_q];

endmodule

// File: tb/tb_issue_div_fifo.sv
module tb_issue_div_fifo;
    import issue_div_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  clk;
    logic                  rst;
    issue_execute_pack_t   data_in;
    logic                  push;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    issue_execute_pack_t   data_out;
    logic                  data_out_valid;
    logic                  pop;
    commit_feedback_pack_t cf;

    int checks;
    int failures;

    issue_div_fifo #(.DEPTH(DEPTH)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .issue_div_fifo_data_in        (data_in),
        .issue_div_fifo_push           (push),
        .issue_div_fifo_full           (full),
        .issue_div_fifo_empty          (empty),
        .issue_div_fifo_count          (count),
        .issue_div_fifo_data_out       (data_out),
        .issue_div_fifo_data_out_valid (data_out_valid),
        .issue_div_fifo_pop            (pop),
        .commit_feedback_pack          (cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic       pop;
        logic       flush;
        logic [6:0] rob;
        int         cnt;
        logic       full;
        logic [6:0] head;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic issue_execute_pack_t mkpack(input logic [6:0] rob);
        issue_execute_pack_t p;
        p             = '0;
        p.enable      = 1'b1;
        p.valid       = 1'b1;
        p.rob_id      = rob;
        p.pc          = 32'h1000 + {25'd0, rob} * 4;
        p.src1_value  = {25'd0, rob};
        p.rd_phy      = rob[5:0];
        p.rd_enable   = 1'b1;
        p.sub_op.div  = DIV_OP_DIV;
        return p;
    endfunction

    function automatic vec_t mk(input logic pu, input logic po, input logic fl, input logic [6:0] rob,
                                input int cnt, input logic fu, input logic [6:0] head);
        vec_t v;
        v.push = pu; v.pop = po; v.flush = fl; v.rob = rob;
        v.cnt = cnt; v.full = fu; v.head = head;
        return v;
    endfunction

    task automatic drive(input logic pu, input logic po, input logic fl, input logic [6:0] rob);
        push      = pu;
        pop       = po;
        cf.enable = fl;
        cf.flush  = fl;
        data_in   = mkpack(rob);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic fu, input logic [6:0] head);
        chk({tag, "_count"}, 256'(count), 256'(cnt));
        chk({tag, "_full"}, 256'(full), 256'(fu));
        chk({tag, "_empty"}, 256'(empty), 256'(cnt == 0));
        chk({tag, "_valid"}, 256'(data_out_valid), 256'(cnt != 0));
        chk({tag, "_enable"}, 256'(data_out.enable), 256'(cnt != 0));
        chk({tag, "_head"}, 256'(data_out.rob_id), 256'(head));
    endtask

    initial begin
        issue_execute_pack_t p;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = '0;
        cf       = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 1'b0, 7'd0);
        chk("reset_data_out", 256'(data_out), 256'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_state($sformatf("idle%0d", i), 0, 1'b0, 7'd0);
        end

        // Push to an empty queue must not appear before the edge.
        push    = 1'b1;
        data_in = mkpack(7'd50);
        #2;
        chk("nobypass_valid", 256'(data_out_valid), 256'd0);
        @(posedge clk);
        #1;
        chk_state("push50", 1, 1'b0, 7'd50);
        drive(1'b0, 1'b1, 1'b0, 7'd0);
        chk_state("pop50", 0, 1'b0, 7'd0);

        // Fill, overflow, drain
        vt.push_back(mk(1, 0, 0, 7'd1, 1, 0, 7'd1));
        vt.push_back(mk(1, 0, 0, 7'd2, 2, 0, 7'd1));
        vt.push_back(mk(1, 0, 0, 7'd3, 3, 0, 7'd1));
        vt.push_back(mk(1, 0, 0, 7'd4, 4, 1, 7'd1));
        vt.push_back(mk(1, 0, 0, 7'd5, 4, 1, 7'd1));
        vt.push_back(mk(0, 1, 0, 7'd0, 3, 0, 7'd2));
        vt.push_back(mk(0, 1, 0, 7'd0, 2, 0, 7'd3));
        vt.push_back(mk(0, 1, 0, 7'd0, 1, 0, 7'd4));
        vt.push_back(mk(0, 1, 0, 7'd0, 0, 0, 7'd0));
        vt.push_back(mk(0, 1, 0, 7'd0, 0, 0, 7'd0));
        // Steady push+pop at count 1: pointers wrap twice
        vt.push_back(mk(1, 0, 0, 7'd10, 1, 0, 7'd10));
        for (int i = 11; i <= 20; i++) vt.push_back(mk(1, 1, 0, 7'(i), 1, 0, 7'(i)));
        // Push+pop while full: push rejected, 9 never surfaces
        vt.push_back(mk(1, 0, 0, 7'd21, 2, 0, 7'd20));
        vt.push_back(mk(1, 0, 0, 7'd22, 3, 0, 7'd20));
        vt.push_back(mk(1, 0, 0, 7'd23, 4, 1, 7'd20));
        vt.push_back(mk(1, 1, 0, 7'd9,  3, 0, 7'd21));
        vt.push_back(mk(0, 1, 0, 7'd0,  2, 0, 7'd22));
        vt.push_back(mk(0, 1, 0, 7'd0,  1, 0, 7'd23));
        vt.push_back(mk(0, 1, 0, 7'd0,  0, 0, 7'd0));
        // Flush with push+pop at count 3
        vt.push_back(mk(1, 0, 0, 7'd30, 1, 0, 7'd30));
        vt.push_back(mk(1, 0, 0, 7'd31, 2, 0, 7'd30));
        vt.push_back(mk(1, 0, 0, 7'd32, 3, 0, 7'd30));
        vt.push_back(mk(1, 1, 1, 7'd33, 0, 0, 7'd0));
        vt.push_back(mk(1, 0, 0, 7'd7,  1, 0, 7'd7));
        vt.push_back(mk(0, 1, 0, 7'd0,  0, 0, 7'd0));
        // Pop while empty alongside a push: only the push lands
        vt.push_back(mk(1, 1, 0, 7'd40, 1, 0, 7'd40));
        vt.push_back(mk(0, 1, 0, 7'd0,  0, 0, 7'd0));

        foreach (vt[i]) begin
            drive(vt[i].push, vt[i].pop, vt[i].flush, vt[i].rob);
            chk_state($sformatf("vec%0d", i), vt[i].cnt, vt[i].full, vt[i].head);
        end

        // Exception-carrying pack returned bit-exact
        p                 = '0;
        p.enable          = 1'b1;
        p.valid           = 1'b1;
        p.pc              = 32'hdeadbeec;
        p.value           = 32'ha5a5a5a5;
        p.src1_value      = 32'h80000000;
        p.src2_value      = 32'hffffffff;
        p.sub_op.div      = DIV_OP_REM;
        p.has_exception   = 1'b1;
        p.exception_id    = 4'd2;
        p.exception_value = 32'h00001234;
        p.rob_id          = 7'h55;
        p.rd_enable       = 1'b1;
        p.rd_phy          = 6'h2a;
        push      = 1'b1;
        pop       = 1'b0;
        cf        = '0;
        data_in   = p;
        @(posedge clk);
        #1;
        push    = 1'b0;
        data_in = '0;
        chk("exc_pack", 256'(data_out), 256'(p));
        chk("exc_src1", 256'(data_out.src1_value), 256'h80000000);
        chk("exc_src2", 256'(data_out.src2_value), 256'hffffffff);
        chk("exc_subop", 256'(data_out.sub_op.raw_data), 256'd2);
        chk("exc_has", 256'(data_out.has_exception), 256'd1);
        chk("exc_id", 256'(data_out.exception_id), 256'd2);
        drive(1'b0, 1'b1, 1'b0, 7'd0);
        chk_state("exc_pop", 0, 1'b0, 7'd0);

        // Flush bit without enable is ignored
        drive(1'b1, 1'b0, 1'b0, 7'd60);
        drive(1'b1, 1'b0, 1'b0, 7'd61);
        push      = 1'b0;
        cf.enable = 1'b0;
        cf.flush  = 1'b1;
        @(posedge clk);
        #1;
        chk_state("flush_noen", 2, 1'b0, 7'd60);
        cf = '0;

        // Reset mid-operation with push and pop active
        rst  = 1'b1;
        push = 1'b1;
        pop  = 1'b1;
        data_in = mkpack(7'd63);
        @(posedge clk);
        #1;
        chk_state("midrst", 0, 1'b0, 7'd0);
        chk("midrst_data_out", 256'(data_out), 256'd0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 7'd62);
        chk_state("postrst", 1, 1'b0, 7'd62);
        drive(1'b0, 1'b1, 1'b0, 7'd0);
        chk_state("postrst_pop", 0, 1'b0, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
